dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
Memory-side responder for the core's data-memory interface. It accepts one load/store request at a time over a valid/ready request channel and holds a word-addressed SRAM array. Stores apply the byte-lane write mask produced by the core. Loads return the full aligned 32-bit word on a valid/ready response channel, and the core performs lane selection and sign extension. WAIT_STATES inserts a programmable access latency so the core's stall handling can be exercised.

Parameters:
DEPTH, 1024, number of 32-bit words in the array (power of two, >=4)
WAIT_STATES, 0, extra cycles spent in BUSY before the access executes (0..15)

Ports:
clk  input  1  single clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  responder can accept a request
req_addr  input  32  byte address; word index = req_addr[31:2]
req_we  input  1  1 = store, 0 = load
req_wmask  input  4  byte-lane write enables for stores (bit i = bits 8i+7:8i)
req_wdata  input  32  store data, already lane-replicated by the core
rsp_valid  output  1  response present
rsp_ready  input  1  core accepts response
rsp_rdata  output  32  load data (full aligned word); 0 for stores and errors
rsp_err  output  1  address out of range (word index >= DEPTH)

Behaviour:
- Reset values: req_ready=0 while rst_n=0, then 1 in IDLE; rsp_valid=0, rsp_rdata=0, rsp_err=0; FSM=IDLE; wait counter=0. Reset does not clear array contents.
- FSM has three states: IDLE, BUSY, RESP. req_ready = (state==IDLE). Only one transaction is outstanding, with no pipelining.
- IDLE: if req_valid, the edge latches addr/we/wmask/wdata and loads counter=WAIT_STATES. The state moves to BUSY.
- BUSY: if counter!=0, decrement it. If counter==0, execute the access on this edge and move to RESP.
  - In-range store: write bytes where wmask=1; other bytes are unchanged. A wmask of 0000 is legal: no write, normal response.
  - In-range load: rsp_rdata = mem[idx]. addr[1:0] and wmask are ignored for loads.
  - Out of range (addr[31:2] >= DEPTH): no write, rsp_rdata=0, rsp_err=1.
  - Store in range: rsp_rdata=0, rsp_err=0.
- Latency: with acceptance in cycle T, rsp_valid is first high in cycle T+2+WAIT_STATES.
- RESP: rsp_valid=1. rsp_rdata and rsp_err are held stable until rsp_ready=1. On the handshake edge: rsp_valid->0, rsp_rdata->0, rsp_err->0, state->IDLE. req_ready is high the next cycle.
- req_valid during BUSY/RESP is ignored, since req_ready=0. The core must hold the request until it is accepted.
- Read-after-write: a load accepted after a store's response returns the stored data. The array is written only in BUSY, so there is no hazard.
- rst_n low mid-transaction: the FSM returns to IDLE asynchronously and the pending response is dropped. A store is not executed unless its BUSY-exit edge already occurred.
- Array: DEPTH x 32 register/inferred RAM with a synchronous, byte-enabled write port. The read is registered into rsp_rdata.

Test Plan:
1. Reset then idle, WAIT_STATES=0 -> req_ready=1, rsp_valid=0, rsp_rdata=0 one cycle after rst_n rises.
2. Store addr=0x10, wdata=0xDEADBEEF, wmask=1111, then load addr=0x10 -> rsp_rdata=0xDEADBEEF, rsp_err=0. rsp_valid is first high 2 cycles after each accept.
3. Store wdata=0x55555555 wmask=0010 to addr=0x11 over a word holding 0x11223344, then load addr=0x10 -> rsp_rdata=0x11225544.
4. WAIT_STATES=3, load accepted in cycle T -> rsp_valid first high in T+5. Hold rsp_ready=0 for 4 cycles -> rsp_valid and data stable, req_ready=0 throughout.
5. DEPTH=1024, store to addr=0x1000 -> rsp_err=1, rsp_rdata=0. Load of word 0 is still unchanged.
6. Assert rst_n=0 while in BUSY with WAIT_STATES=3 -> rsp_valid=0 immediately and the targeted word is unmodified. After release, a new request is accepted.

Source files
------------

// File: rtl/dmem_responder_if.sv
// Data-memory request/response bundle between core (master) and responder (slave).
// No logic; carries the valid/ready request and response channels.
// Backpressure flows on req_ready and rsp_ready.
interface dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_we;
    logic [3:0]  req_wmask;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_addr, req_we, req_wmask, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_addr, req_we, req_wmask, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder over a word-addressed byte-enabled array.
// Latency: response valid 2+WAIT_STATES cycles after request acceptance.
// Backpressure: req_ready only in IDLE; response held stable until rsp_ready.
module dmem_responder #(
    parameter int DEPTH       = 1024,
    parameter int WAIT_STATES = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    dmem_responder_if.slave   bus
);
    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q;
    logic [29:0] addr_q;
    logic        we_q;
    logic [3:0]  wmask_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        err_q;
    logic        accept, exec, rsp_hs;
    logic        in_range;
    logic [IDX_W-1:0] idx;
    logic [31:0] mem [DEPTH];

    // Byte offset is meaningless to a word-wide responder; the core does lane selection.
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^bus.req_addr[1:0];

    assign in_range = (addr_q[29:IDX_W] == '0);
    assign idx      = addr_q[IDX_W-1:0];

    assign bus.req_ready = rst_n && (state_q == IDLE);
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        exec    = 1'b0;
        rsp_hs  = 1'b0;
        unique case (state_q)
            IDLE: if (bus.req_valid) begin
                accept  = 1'b1;
                state_d = BUSY;
            end
            BUSY: if (cnt_q == 4'd0) begin
                exec    = 1'b1;
                state_d = RESP;
            end
            RESP: if (bus.rsp_ready) begin
                rsp_hs  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wmask_q <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                addr_q  <= bus.req_addr[31:2];
                we_q    <= bus.req_we;
                wmask_q <= bus.req_wmask;
                wdata_q <= bus.req_wdata;
                cnt_q   <= 4'(WAIT_STATES);
            end else if (state_q == BUSY && cnt_q != 4'd0) begin
                cnt_q <= cnt_q - 4'd1;
            end
            if (exec) begin
                err_q   <= !in_range;
                rdata_q <= (in_range && !we_q) ? mem[idx] : 32'd0;
            end else if (rsp_hs) begin
                err_q   <= 1'b0;
                rdata_q <= 32'd0;
            end
        end
    end

    // Array is intentionally not reset; writes happen only on the BUSY-exit edge.
    always_ff @(posedge clk) begin
        if (exec && we_q && in_range) begin
            for (int i = 0; i < 4; i++) begin
                if (wmask_q[i]) mem[idx][8*i +: 8] <= wdata_q[8*i +: 8];
            end
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance with no wait states, one with three.
// Request/response fields are shared; sel picks which instance a transaction targets.
module tb_dmem_responder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sel = 1'b0;
    logic        req_valid = 1'b0;
    logic [31:0] req_addr = '0;
    logic        req_we = 1'b0;
    logic [3:0]  req_wmask = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_ready = 1'b0;

    logic        cur_req_ready, cur_rsp_valid, cur_rsp_err;
    logic [31:0] cur_rsp_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmem_responder_if if0 ();
    dmem_responder_if if3 ();

    assign if0.req_valid = req_valid & ~sel;
    assign if3.req_valid = req_valid &  sel;
    assign if0.rsp_ready = rsp_ready & ~sel;
    assign if3.rsp_ready = rsp_ready &  sel;
    assign if0.req_addr  = req_addr;
    assign if3.req_addr  = req_addr;
    assign if0.req_we    = req_we;
    assign if3.req_we    = req_we;
    assign if0.req_wmask = req_wmask;
    assign if3.req_wmask = req_wmask;
    assign if0.req_wdata = req_wdata;
    assign if3.req_wdata = req_wdata;

    assign cur_req_ready = sel ? if3.req_ready : if0.req_ready;
    assign cur_rsp_valid = sel ? if3.rsp_valid : if0.rsp_valid;
    assign cur_rsp_rdata = sel ? if3.rsp_rdata : if0.rsp_rdata;
    assign cur_rsp_err   = sel ? if3.rsp_err   : if0.rsp_err;

    dmem_responder #(.DEPTH(1024), .WAIT_STATES(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    dmem_responder #(.DEPTH(1024), .WAIT_STATES(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(if3));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One full transaction; hold = cycles to keep rsp_ready low after rsp_valid rises.
    task automatic do_txn(input bit s, input bit we, input logic [31:0] addr,
                          input logic [3:0] wmask, input logic [31:0] wdata,
                          input logic [31:0] exp_rdata, input bit exp_err,
                          input int hold, input string tag);
        int n;
        @(negedge clk);
        sel = s; req_we = we; req_addr = addr; req_wmask = wmask; req_wdata = wdata;
        req_valid = 1'b1;
        #1 chk({tag, "/req_ready"}, 32'(cur_req_ready), 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!cur_rsp_valid && n < 40);
        chk({tag, "/latency"}, 32'(n), s ? 32'd5 : 32'd2);
        chk({tag, "/rdata"}, cur_rsp_rdata, exp_rdata);
        chk({tag, "/err"}, 32'(cur_rsp_err), 32'(exp_err));
        for (int i = 0; i < hold; i++) begin
            req_valid = 1'b1;
            req_we = 1'b1; req_wmask = 4'hF; req_wdata = 32'hBAD0BAD0;
            @(negedge clk);
            chk({tag, "/hold_valid"}, 32'(cur_rsp_valid), 32'd1);
            chk({tag, "/hold_rdata"}, cur_rsp_rdata, exp_rdata);
            chk({tag, "/hold_req_ready"}, 32'(cur_req_ready), 32'd0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        chk({tag, "/post_valid"}, 32'(cur_rsp_valid), 32'd0);
        chk({tag, "/post_rdata"}, cur_rsp_rdata, 32'd0);
        chk({tag, "/post_err"}, 32'(cur_rsp_err), 32'd0);
        chk({tag, "/post_req_ready"}, 32'(cur_req_ready), 32'd1);
    endtask

    initial begin
        int n;
        repeat (2) @(negedge clk);
        chk("rst/req_ready_low", 32'(if0.req_ready), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst/req_ready", 32'(if0.req_ready), 32'd1);
        chk("rst/rsp_valid", 32'(if0.rsp_valid), 32'd0);
        chk("rst/rsp_rdata", if0.rsp_rdata, 32'd0);
        chk("rst/rsp_err", 32'(if0.rsp_err), 32'd0);

        // Basic store/load round trip
        do_txn(0, 1, 32'h10, 4'hF, 32'hDEADBEEF, 32'd0, 0, 0, "st_full");
        do_txn(0, 0, 32'h10, 4'h0, 32'd0, 32'hDEADBEEF, 0, 0, "ld_full");

        // Single-lane merge: lane 1 of 0x11223344 replaced by 0x55
        do_txn(0, 1, 32'h10, 4'hF, 32'h11223344, 32'd0, 0, 0, "st_base");
        do_txn(0, 1, 32'h11, 4'b0010, 32'h55555555, 32'd0, 0, 0, "st_lane1");
        do_txn(0, 0, 32'h10, 4'h0, 32'd0, 32'h11225544, 0, 0, "ld_merge");
        do_txn(0, 1, 32'h10, 4'b0000, 32'hFFFFFFFF, 32'd0, 0, 0, "st_nomask");
        do_txn(0, 0, 32'h13, 4'hF, 32'd0, 32'h11225544, 0, 0, "ld_unaligned");

        // Range boundary: last word valid, first word past the array errors
        do_txn(0, 1, 32'h0, 4'hF, 32'hA5A5A5A5, 32'd0, 0, 0, "st_w0");
        do_txn(0, 1, 32'hFFC, 4'hF, 32'h0BADF00D, 32'd0, 0, 0, "st_last");
        do_txn(0, 0, 32'hFFC, 4'h0, 32'd0, 32'h0BADF00D, 0, 0, "ld_last");
        do_txn(0, 1, 32'h1000, 4'hF, 32'h77777777, 32'd0, 1, 0, "st_oor");
        do_txn(0, 0, 32'h1000, 4'h0, 32'd0, 32'd0, 1, 0, "ld_oor");
        do_txn(0, 0, 32'h0, 4'h0, 32'd0, 32'hA5A5A5A5, 0, 0, "ld_w0");

        // Wait states and response backpressure
        do_txn(1, 1, 32'h40, 4'hF, 32'hCAFEF00D, 32'd0, 0, 0, "ws_st");
        do_txn(1, 0, 32'h40, 4'h0, 32'd0, 32'hCAFEF00D, 0, 4, "ws_ld_hold");
        do_txn(1, 0, 32'h40, 4'h0, 32'd0, 32'hCAFEF00D, 0, 0, "ws_ld_again");

        // Reset during BUSY drops the store
        do_txn(1, 1, 32'h44, 4'hF, 32'h12345678, 32'd0, 0, 0, "ws_st_base");
        @(negedge clk);
        sel = 1'b1; req_we = 1'b1; req_addr = 32'h44; req_wmask = 4'hF;
        req_wdata = 32'hFFFFFFFF; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1 chk("rst_busy/rsp_valid", 32'(if3.rsp_valid), 32'd0);
        chk("rst_busy/req_ready", 32'(if3.req_ready), 32'd0);
        repeat (6) @(negedge clk);
        rst_n = 1'b1;
        do_txn(1, 0, 32'h44, 4'h0, 32'd0, 32'h12345678, 0, 0, "rst_busy_ld");

        // Reset while a response is pending drops it immediately
        @(negedge clk);
        sel = 1'b1; req_we = 1'b0; req_addr = 32'h44; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!if3.rsp_valid && n < 40);
        chk("rst_resp/valid_before", 32'(if3.rsp_valid), 32'd1);
        rst_n = 1'b0;
        #1 chk("rst_resp/rsp_valid", 32'(if3.rsp_valid), 32'd0);
        chk("rst_resp/rsp_rdata", if3.rsp_rdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        do_txn(1, 0, 32'h40, 4'h0, 32'd0, 32'hCAFEF00D, 0, 0, "after_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
